// File: rtl/dice_pkg.sv
// Shared constants for the dice game: die range, sum width and the sums
// that the controller cares about.
package dice_pkg;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  localparam int SUM_W = 4;

  localparam logic [SUM_W-1:0] SUM_2  = 4'd2;
  localparam logic [SUM_W-1:0] SUM_3  = 4'd3;
  localparam logic [SUM_W-1:0] SUM_7  = 4'd7;
  localparam logic [SUM_W-1:0] SUM_11 = 4'd11;
  localparam logic [SUM_W-1:0] SUM_12 = 4'd12;

endpackage

// File: rtl/die_counter.sv
// One die: counts DIE_MIN..DIE_MAX while enabled, flags the wrap back to
// DIE_MIN so a second die can be chained off it.
module die_counter
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] value,
  output logic       wrap
);

  logic [2:0] value_q;
  logic [2:0] value_d;

  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = (value_q == DIE_MAX) ? DIE_MIN : value_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= DIE_MIN;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = en & (value_q == DIE_MAX);

endmodule

// File: rtl/dice_datapath.sv
// Dice datapath: two chained die counters, sum decode for the controller,
// the saved point and a saturating count of completed rolls.
module dice_datapath
  import dice_pkg::*;
#(
  parameter int ROLL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Roll,
  input  logic                  sp,
  input  logic                  clr,
  output logic [2:0]            die1,
  output logic [2:0]            die2,
  output logic [SUM_W-1:0]      sum,
  output logic [SUM_W-1:0]      point,
  output logic                  point_valid,
  output logic                  D7,
  output logic                  D11,
  output logic                  D2312,
  output logic                  EQ,
  output logic [ROLL_CNT_W-1:0] roll_cnt
);

  localparam logic [ROLL_CNT_W-1:0] ROLL_CNT_MAX = {ROLL_CNT_W{1'b1}};

  logic die1_wrap;
  logic die2_wrap;

  die_counter u_die1 (
    .clk   (clk),
    .reset (reset),
    .en    (Roll),
    .value (die1),
    .wrap  (die1_wrap)
  );

  die_counter u_die2 (
    .clk   (clk),
    .reset (reset),
    .en    (die1_wrap),
    .value (die2),
    .wrap  (die2_wrap)
  );

  logic                  unused_wrap;
  logic [SUM_W-1:0]      point_q, point_d;
  logic                  point_valid_q, point_valid_d;
  logic                  roll_q, roll_d;
  logic [ROLL_CNT_W-1:0] roll_cnt_q, roll_cnt_d;
  logic                  roll_fall;

  assign unused_wrap = die2_wrap;

  assign sum   = {1'b0, die1} + {1'b0, die2};
  assign D7    = (sum == SUM_7);
  assign D11   = (sum == SUM_11);
  assign D2312 = (sum == SUM_2) | (sum == SUM_3) | (sum == SUM_12);
  assign EQ    = point_valid_q & (sum == point_q);

  assign roll_fall = roll_q & ~Roll;

  // clr takes priority over both sp and a coincident roll completion.
  always_comb begin
    point_d       = point_q;
    point_valid_d = point_valid_q;
    roll_cnt_d    = roll_cnt_q;
    roll_d        = Roll;
    if (clr) begin
      point_d       = '0;
      point_valid_d = 1'b0;
      roll_cnt_d    = '0;
    end else begin
      if (sp) begin
        point_d       = sum;
        point_valid_d = 1'b1;
      end
      if (roll_fall && (roll_cnt_q != ROLL_CNT_MAX)) begin
        roll_cnt_d = roll_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      point_q       <= '0;
      point_valid_q <= 1'b0;
      roll_q        <= 1'b0;
      roll_cnt_q    <= '0;
    end else begin
      point_q       <= point_d;
      point_valid_q <= point_valid_d;
      roll_q        <= roll_d;
      roll_cnt_q    <= roll_cnt_d;
    end
  end

  assign point       = point_q;
  assign point_valid = point_valid_q;
  assign roll_cnt    = roll_cnt_q;

endmodule
